// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states and
// the byte-enable encodings accepted on the data bus.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Only naturally aligned byte, halfword and word lane patterns are legal.
  function automatic logic be_legal(input logic [3:0] be);
    logic legal;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-organised storage: synchronous byte-enable write, asynchronous read,
// both at the same word index. Contents are deliberately not reset.
module dmem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for load/store traffic: req/gnt/rvalid handshake with
// a fixed number of wait states, one outstanding transaction at a time.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SIZE_LAU   = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned DEPTH = SIZE_LAU / 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(SIZE_LAU);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_grant;
  logic                  w_err;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_grant = req_i && (r_state == IDLE);
  assign w_err   = (r_addr >= LIMIT) || !be_legal(r_be);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_addr  <= addr_i;
        r_we    <= we_i;
        r_be    <= be_i;
        r_wdata <= wdata_i;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (req_i) w_next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_cnt == '0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The write commits on the edge that ends RESP, so an async reset landing
  // in WAIT or RESP returns to IDLE before that edge and drops the store.
  always_comb begin
    gnt_o    = w_grant;
    rvalid_o = 1'b0;
    err_o    = 1'b0;
    rdata_o  = '0;
    w_mem_we = 1'b0;
    if (r_state == RESP) begin
      rvalid_o = 1'b1;
      err_o    = w_err;
      w_mem_we = r_we && !w_err;
      if (!w_err && !r_we) rdata_o = w_mem_rdata;
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (r_be),
    .i_idx   (r_addr[IDX_W+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 4) checked against a
// word-array reference model with directed and randomized transactions.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        t_req   [3];
  logic        t_we    [3];
  logic [3:0]  t_be    [3];
  logic [31:0] t_addr  [3];
  logic [31:0] t_wdata [3];
  logic        t_gnt   [3];
  logic        t_rvalid[3];
  logic        t_err   [3];
  logic [31:0] t_rdata [3];

  bit [31:0] mm[3][256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SIZE_LAU(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_i(t_req[0]), .gnt_o(t_gnt[0]), .addr_i(t_addr[0]),
    .we_i(t_we[0]), .be_i(t_be[0]), .wdata_i(t_wdata[0]), .rvalid_o(t_rvalid[0]),
    .rdata_o(t_rdata[0]), .err_o(t_err[0]));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SIZE_LAU(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_i(t_req[1]), .gnt_o(t_gnt[1]), .addr_i(t_addr[1]),
    .we_i(t_we[1]), .be_i(t_be[1]), .wdata_i(t_wdata[1]), .rvalid_o(t_rvalid[1]),
    .rdata_o(t_rdata[1]), .err_o(t_err[1]));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SIZE_LAU(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_i(t_req[2]), .gnt_o(t_gnt[2]), .addr_i(t_addr[2]),
    .we_i(t_we[2]), .be_i(t_be[2]), .wdata_i(t_wdata[2]), .rvalid_o(t_rvalid[2]),
    .rdata_o(t_rdata[2]), .err_o(t_err[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input logic [31:0] a, input logic [3:0] b);
    return (a >= 32'd1024) ||
           !(b inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
  endfunction

  // Reference behaviour: applies a transaction to the model, returns expectations.
  function automatic void ref_apply(input int d, input logic [31:0] a, input logic w,
                                    input logic [3:0] b, input logic [31:0] wd,
                                    output logic [31:0] exp_rd, output logic exp_err);
    exp_err = ref_err(a, b);
    exp_rd  = '0;
    if (!exp_err) begin
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) mm[d][a[9:2]][k*8 +: 8] = wd[k*8 +: 8];
      end else begin
        exp_rd = mm[d][a[9:2]];
      end
    end
  endfunction

  // Drives one request; reports grant wait, grant-to-rvalid latency and response.
  task automatic do_txn(input int d, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e,
                        output int gwait, output int lat, output bit tmo);
    tmo = 1'b0; gwait = 0; lat = 0; rd = '0; e = 1'b0;
    @(negedge clk);
    t_req[d] = 1'b1; t_addr[d] = a; t_we[d] = w; t_be[d] = b; t_wdata[d] = wd;
    #1;
    while (t_gnt[d] !== 1'b1) begin
      if (gwait >= 20) begin tmo = 1'b1; t_req[d] = 1'b0; return; end
      @(negedge clk); #1; gwait++;
    end
    @(negedge clk);
    t_req[d] = 1'b0; t_addr[d] = $urandom; t_we[d] = ~w; t_be[d] = ~b; t_wdata[d] = $urandom;
    lat = 1;
    #1;
    while (t_rvalid[d] !== 1'b1) begin
      if (lat >= 20) begin tmo = 1'b1; return; end
      @(negedge clk); #1; lat++;
    end
    rd = t_rdata[d];
    e  = t_err[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      t_req[d] = 1'b0; t_we[d] = 1'b0; t_be[d] = '0; t_addr[d] = '0; t_wdata[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (t_rvalid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid[%0d]: got %b expected 0", d, t_rvalid[d]); end
      n_tests++;
      if (t_gnt[d] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b expected 0", d, t_gnt[d]); end
      n_tests++;
      if (t_err[d] !== 1'b0 || t_rdata[d] !== 32'h0) begin
        n_fail++; $display("FAIL reset_resp[%0d]: got err=%b rdata=%h expected 0/0", d, t_err[d], t_rdata[d]);
      end
    end
  endtask

  task automatic test_init();
    logic [31:0] rd, er, wd; logic e; int gw, lt; bit tmo;
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 256; w++) begin
        wd = $urandom;
        ref_apply(d, 32'(w * 4), 1'b1, 4'hF, wd, er, e);
        do_txn(d, 32'(w * 4), 1'b1, 4'hF, wd, rd, e, gw, lt, tmo);
        n_tests++;
        if (tmo || lt != lat_of(d) || e !== 1'b0 || rd !== 32'h0) begin
          n_fail++;
          $display("FAIL init_write[%0d] w=%0d: got tmo=%0d lat=%0d err=%b rdata=%h expected 0/%0d/0/0",
                   d, w, tmo, lt, e, rd, lat_of(d));
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd; logic e; int gw, lt; bit tmo;
    mm[1][4] = 32'hA0B0C0D0;
    do_txn(1, 32'h10, 1'b1, 4'hF, 32'hA0B0C0D0, rd, e, gw, lt, tmo);
    n_tests++;
    if (tmo || gw != 0 || lt != 2 || e !== 1'b0) begin
      n_fail++; $display("FAIL first_write: got tmo=%0d gwait=%0d lat=%0d err=%b expected 0/0/2/0", tmo, gw, lt, e);
    end
    do_txn(1, 32'h10, 1'b0, 4'hF, 32'h0, rd, e, gw, lt, tmo);
    n_tests++;
    if (tmo || rd !== 32'hA0B0C0D0 || e !== 1'b0) begin
      n_fail++; $display("FAIL read_back: got %h err=%b expected a0b0c0d0 err=0", rd, e);
    end
    mm[1][4] = 32'hA0B0EED0;
    do_txn(1, 32'h11, 1'b1, 4'b0010, 32'h0000EE00, rd, e, gw, lt, tmo);
    do_txn(1, 32'h10, 1'b0, 4'hF, 32'h0, rd, e, gw, lt, tmo);
    n_tests++;
    if (tmo || rd !== 32'hA0B0EED0) begin
      n_fail++; $display("FAIL byte_write: got %h expected a0b0eed0", rd);
    end
    mm[1][4] = 32'h80017FFF;
    do_txn(1, 32'h10, 1'b1, 4'hF, 32'h80017FFF, rd, e, gw, lt, tmo);
    do_txn(1, 32'h12, 1'b0, 4'b1100, 32'h0, rd, e, gw, lt, tmo);
    n_tests++;
    if (tmo || rd !== 32'h80017FFF || e !== 1'b0) begin
      n_fail++; $display("FAIL halfword_read: got %h err=%b expected 80017fff err=0", rd, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, er; logic e, ee; int gw, lt; bit tmo;
    logic [31:0] ea [6] = '{32'h20, 32'h400, 32'hFFFFFFFC, 32'h0, 32'h3FC, 32'h401};
    logic        ew [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  eb [6] = '{4'b0110, 4'hF, 4'hF, 4'b0000, 4'b0101, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      ref_apply(1, ea[i], ew[i], eb[i], 32'hDEADBEEF, er, ee);
      do_txn(1, ea[i], ew[i], eb[i], 32'hDEADBEEF, rd, e, gw, lt, tmo);
      n_tests++;
      if (tmo || e !== 1'b1 || ee !== 1'b1 || rd !== 32'h0) begin
        n_fail++; $display("FAIL error_case%0d: got tmo=%0d err=%b rdata=%h expected err=1 rdata=0", i, tmo, e, rd);
      end
    end
    ref_apply(1, 32'h3FC, 1'b0, 4'hF, 32'h0, er, ee);
    do_txn(1, 32'h3FC, 1'b0, 4'hF, 32'h0, rd, e, gw, lt, tmo);
    n_tests++;
    if (tmo || rd !== er || e !== 1'b0) begin
      n_fail++; $display("FAIL storage_after_errors: got %h err=%b expected %h err=0", rd, e, er);
    end
  endtask

  task automatic test_back_to_back();
    int L, n; logic eg, ev;
    for (int d = 0; d < 3; d++) begin
      L = lat_of(d);
      n = 3 * (L + 1);
      @(negedge clk);
      t_req[d] = 1'b1; t_addr[d] = 32'h3FC; t_we[d] = 1'b0; t_be[d] = 4'hF; t_wdata[d] = '0;
      for (int i = 0; i < n; i++) begin
        #1;
        eg = (i % (L + 1)) == 0;
        ev = (i % (L + 1)) == L;
        n_tests++;
        if (t_gnt[d] !== eg || t_rvalid[d] !== ev) begin
          n_fail++; $display("FAIL b2b[%0d] cycle %0d: got gnt=%b rvalid=%b expected %b/%b",
                             d, i, t_gnt[d], t_rvalid[d], eg, ev);
        end
        if (ev) begin
          n_tests++;
          if (t_rdata[d] !== mm[d][255]) begin
            n_fail++; $display("FAIL b2b_data[%0d] cycle %0d: got %h expected %h", d, i, t_rdata[d], mm[d][255]);
          end
        end
        @(negedge clk);
      end
      t_req[d] = 1'b0;
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic e; int gw, lt; bit tmo, seen;
    @(negedge clk);
    t_req[2] = 1'b1; t_addr[2] = 32'h40; t_we[2] = 1'b1; t_be[2] = 4'hF; t_wdata[2] = ~mm[2][16];
    #1;
    n_tests++;
    if (t_gnt[2] !== 1'b1) begin n_fail++; $display("FAIL rst_wait_grant: got %b expected 1", t_gnt[2]); end
    @(negedge clk);
    t_req[2] = 1'b0;
    seen = 1'b0;
    #1; if (t_rvalid[2] === 1'b1) seen = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk); #1;
      if (t_rvalid[2] !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL rst_wait_rvalid: got rvalid=1 expected none"); end
    do_txn(2, 32'h40, 1'b0, 4'hF, 32'h0, rd, e, gw, lt, tmo);
    n_tests++;
    if (tmo || gw != 0) begin n_fail++; $display("FAIL rst_wait_regrant: got gwait=%0d tmo=%0d expected 0/0", gw, tmo); end
    n_tests++;
    if (rd !== mm[2][16] || e !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_word: got %h err=%b expected %h err=0", rd, e, mm[2][16]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, er; logic w, e, ee; logic [3:0] b; int gw, lt, r; bit tmo;
    logic [3:0] legal [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 80; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = $urandom;
        else if (r == 1) a = 32'h3FC + 32'($urandom_range(0, 7));
        else             a = 32'($urandom_range(0, 1023));
        b  = ($urandom_range(0, 1) == 0) ? legal[$urandom_range(0, 6)] : 4'($urandom);
        w  = 1'($urandom);
        wd = $urandom;
        ref_apply(d, a, w, b, wd, er, ee);
        do_txn(d, a, w, b, wd, rd, e, gw, lt, tmo);
        n_tests++;
        if (tmo || lt != lat_of(d) || e !== ee || rd !== er) begin
          n_fail++;
          $display("FAIL random[%0d] #%0d a=%h we=%b be=%b: got tmo=%0d lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
                   d, k, a, w, b, tmo, lt, e, rd, lat_of(d), ee, er);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_errors();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for load/store traffic. It answers the core's data requests over a req/gnt/rvalid handshake with a configurable number of wait states.
- Stores data in byte-addressable, little-endian word storage.
- Applies byte-enable writes.
- Returns full lane-aligned words. The initiator does byte/halfword extraction and sign/zero extension.
- Flags illegal accesses.

It sits between the load/store unit and data memory, and it is the first step toward a stallable data bus.

Parameters:
DATA_WIDTH, 32, data bus width (only 32 supported)
ADDR_WIDTH, 32, byte address width
SIZE_LAU, 1024, memory size in bytes (multiple of 4)
LATENCY, 2, cycles from grant cycle to rvalid cycle (legal range 1..15)

Ports:
clk      input   1           clock, rising edge
rst_n    input   1           asynchronous active-low reset
req_i    input   1           initiator request; addr/we/be/wdata valid while high
gnt_o    output  1           request accepted this cycle (combinational)
addr_i   input   ADDR_WIDTH  byte address
we_i     input   1           1 = write, 0 = read
be_i     input   4           byte enables; bit n = byte lane n (addr offset n)
wdata_i  input   DATA_WIDTH  write data, lane-aligned
rvalid_o output  1           one-cycle response strobe (reads and writes)
rdata_o  output  DATA_WIDTH  lane-aligned read word, valid with rvalid_o
err_o    output  1           access error, valid with rvalid_o

Behaviour:
- Reset (async assert, sync deassert handled by the top level):
  - FSM goes to IDLE.
  - rvalid_o, err_o and rdata_o go to 0.
  - Latched request registers are cleared.
  - Memory contents are not reset.
- Handshake and grant:
  - At most one outstanding transaction.
  - gnt_o = req_i && state==IDLE.
  - The request is latched on the clock edge where req_i && gnt_o.
  - The initiator holds req_i and all request fields stable until gnt_o.
  - Fields may change freely after grant.
- FSM states:
  - IDLE:
    - On grant with LATENCY==1, go to RESP.
    - On grant otherwise, load cnt = LATENCY-2 and go to WAIT.
  - WAIT:
    - If cnt==0, go to RESP; else decrement cnt.
    - req_i is ignored and gnt_o=0.
  - RESP:
    - rvalid_o=1 for exactly this cycle; gnt_o=0.
    - Next state is IDLE unconditionally.
    - A request pending during RESP is granted in the following IDLE cycle at the earliest.
  - This gives grant-to-rvalid = LATENCY cycles and back-to-back throughput = one transaction per LATENCY+1 cycles.
- cnt is 4 bits.
- Addressing: word index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored, because lane selection comes from be_i only.
- Error conditions, evaluated on the latched request:
  - addr >= SIZE_LAU (full-width compare, no wrap-around)
  - be == 4'b0000
  - be not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111 (no misaligned halfwords or 3-byte accesses)
- Error response: err_o=1 and rdata_o=0 in the RESP cycle. Storage is unmodified.
- Write without error:
  - Enabled bytes are written on the edge ending the RESP cycle.
  - rdata_o=0 and err_o=0 in the RESP cycle.
  - Disabled lanes are untouched.
- Read without error:
  - rdata_o = the full stored word at the index in the RESP cycle; all lanes are returned regardless of be.
  - No side effects.
- rdata_o and err_o are driven 0 whenever rvalid_o=0.
- Reset during WAIT or RESP drops the transaction: no write occurs and no rvalid is produced.

Decomposition:
- Shared package (add to the existing core package):
  - Byte-enable legality constants or a legality function.
  - The FSM state enum (IDLE, WAIT, RESP).
  - A byte-enable-encoding localparam set: BE_B0..BE_B3, BE_H0, BE_H1, BE_W.
- One sub-module, dmem_array: word-organised storage with a synchronous byte-enable write port and an asynchronous read port, indexed by word.
- FSM, counter, latching and error logic stay in data_mem_responder.

Test Plan:
- Reset with LATENCY=2: after reset, rvalid_o=0, gnt_o=0 with req_i=0. Then write addr 0x10, be=1111, wdata 0xA0B0C0D0 -> gnt_o high in the request cycle and rvalid_o high exactly 2 cycles later with err_o=0. A following read of 0x10 returns 0xA0B0C0D0.
- Byte write: write addr 0x11, be=0010, wdata 0x0000EE00 over word 0xA0B0C0D0 -> read of 0x10 returns 0xA0B0EED0.
- Errors:
  - Read with be=0110 at 0x20 -> err_o=1, rdata_o=0.
  - Write at addr 0x400 (SIZE_LAU=1024) -> err_o=1.
  - A subsequent read of 0x3FC returns the prior contents unchanged.
- Back-to-back with req_i held high, LATENCY=1 -> grants on cycles 0, 2, 4; rvalid_o on cycles 1, 3, 5; gnt_o=0 on every RESP cycle.
- LATENCY=4 with rst_n pulsed low during WAIT -> no rvalid_o at any time, target word unchanged, FSM back in IDLE, and the next request is granted immediately.
- Halfword read of 0x12, be=1100, word 0x8001_7FFF -> rdata_o=0x80017FFF, err_o=0.
